uart_rx: RTL and testbench

Receive side of the SoC debug/console UART: deserialises an asynchronous 8N1 serial line into bytes and presents them on a valid/ready stream toward the core's MMIO peripheral. It is the counterpart of the existing UART transmitter, uses the same baud arithmetic, and talks to it directly in loopback tests. It provides a one-byte output holding register plus sticky-free error pulses for framing errors and overruns.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync2.sv | 25 ++
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the
// baud divider arithmetic used by both the transmitter and the receiver.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } uart_rx_state_e;

  // Clock cycles per bit period; integer division, as the transmitter uses.
  function automatic int baud_count(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for asynchronous inputs. Both flops load
// RESET_VAL during reset so the output never shows a false edge after reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit in its middle using a down-counter,
// assembles bytes LSB first and hands them over through a one-byte holding
// register with valid/ready. Stop-bit errors and dropped bytes are reported
// as single-cycle pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 57600
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] dOut,
  output logic                      dOutValid,
  input  logic                      dOutReady,
  output logic                      frameErr,
  output logic                      overrun
);

  localparam int COUNT = baud_count(CLK_FREQ, BAUD);
  localparam int HALF  = COUNT / 2;
  localparam int CNT_W = $clog2(COUNT) + 1;
  localparam int IDX_W = $clog2(UART_DATA_BITS);

  if (COUNT < 4) begin : g_count_check
    $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
  end

  uart_rx_state_e            state, state_next;
  logic [CNT_W-1:0]          cnt, cnt_next;
  logic [IDX_W-1:0]          bit_idx, bit_idx_next;
  logic [UART_DATA_BITS-1:0] sh, sh_next;
  logic                      rx_s;
  logic                      tick;
  logic                      byte_done;
  logic                      frame_err_next;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx),
    .q    (rx_s)
  );

  assign tick = (cnt == '0);

  // Frame sequencing: half-bit delay to the start-bit middle, then one full
  // bit period per data bit and for the stop bit.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    bit_idx_next   = bit_idx;
    sh_next        = sh;
    byte_done      = 1'b0;
    frame_err_next = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          cnt_next   = CNT_W'(HALF - 1);
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            cnt_next     = CNT_W'(COUNT - 1);
            bit_idx_next = '0;
            state_next   = DATA;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (tick) begin
          sh_next  = {rx_s, sh[UART_DATA_BITS-1:1]};
          cnt_next = CNT_W'(COUNT - 1);
          if (bit_idx == IDX_W'(UART_DATA_BITS - 1)) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + IDX_W'(1);
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            byte_done  = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = BRK;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      BRK: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Receiver state, bit timer, bit index and shift register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      sh      <= sh_next;
    end
  end

  // Holding register and error pulses; a completed byte is lost only when
  // the previous one is still held and not being accepted this cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dOut      <= '0;
      dOutValid <= 1'b0;
      frameErr  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frameErr <= frame_err_next;
      overrun  <= 1'b0;
      if (byte_done) begin
        if (!dOutValid || dOutReady) begin
          dOut      <= sh;
          dOutValid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dOutValid && dOutReady) begin
        dOutValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: a behavioural 8N1 line driver plays the transmitter,
// a monitor collects accepted bytes and error pulses, and directed plus
// random frames are compared against the expected byte stream.
module tb_uart_rx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int COUNT    = CLK_FREQ / BAUD;
  localparam int HALF     = COUNT / 2;
  localparam int LATENCY  = 2 + HALF + 9 * COUNT;

  logic       clk;
  logic       rstn;
  logic       rx;
  logic [7:0] dOut;
  logic       dOutValid;
  logic       dOutReady;
  logic       frameErr;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  int         cyc = 0;
  int         first_valid = -1;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .dOut      (dOut),
    .dOutValid (dOutValid),
    .dOutReady (dOutReady),
    .frameErr  (frameErr),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: after clock edge k, cyc holds k.
  always @(posedge clk) cyc <= cyc + 1;

  // Record handshakes and error pulses in the middle of each cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (dOutValid && dOutReady) got_q.push_back(dOut);
      if (dOutValid && first_valid < 0) first_valid = cyc;
      if (frameErr) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frameErr && overrun) both_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 8'hxx;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  // Drive one frame: start bit, 8 data bits LSB first, stop bit held for
  // stop_len cycles. Optionally pulse dOutReady for one cycle at step
  // pulse_at, or assert reset for one cycle at step rst_at and abandon the
  // frame (line returned to idle).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len,
                            input int pulse_at, input int rst_at);
    for (int s = 0; s < 9 * COUNT + stop_len; s++) begin
      if (s < COUNT) rx = 1'b0;
      else if (s < 9 * COUNT) rx = b[(s / COUNT) - 1];
      else rx = stop_bit;
      if (pulse_at >= 0 && s == pulse_at) dOutReady = 1'b1;
      if (pulse_at >= 0 && s == pulse_at + 1) dOutReady = 1'b0;
      if (s == rst_at) rstn = 1'b0;
      step();
      if (s == rst_at) begin
        rstn = 1'b1;
        rx   = 1'b1;
        return;
      end
    end
    rx = 1'b1;
  endtask

  initial begin
    logic [7:0] lb[4];
    logic [7:0] rb;
    int c0, fe0, ov0, n;

    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h55; lb[3] = 8'h80;

    rx = 1'b1;
    rstn = 1'b0;
    dOutReady = 1'b1;
    repeat (3) step();
    check("reset_dOut", 32'(dOut), 32'h00);
    check("reset_valid", 32'(dOutValid), 32'h0);
    check("reset_frameErr", 32'(frameErr), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    rstn = 1'b1;
    idle(5);

    // Single frame with exact latency from the first low sample.
    got_q.delete();
    c0 = cyc;
    first_valid = -1;
    send_frame(8'hA5, 1'b1, COUNT, -1, -1);
    idle(5);
    check("a5_latency", 32'(first_valid - (c0 + 1)), 32'(LATENCY));
    check("a5_count", 32'(got_q.size()), 32'd1);
    check("a5_byte", 32'(got_at(0)), 32'hA5);

    // Back-to-back frames with zero gap.
    got_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 4; i++) send_frame(lb[i], 1'b1, COUNT, -1, -1);
    idle(5);
    check("loop_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("loop_byte%0d", i), 32'(got_at(i)), 32'(lb[i]));
    check("loop_errors", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

    // Short low glitch on an idle line is ignored.
    got_q.delete();
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (3) step();
    idle(30);
    check("glitch_bytes", 32'(got_q.size()), 32'd0);
    check("glitch_frameErr", 32'(fe_cnt - fe0), 32'd0);
    send_frame(8'h5A, 1'b1, COUNT, -1, -1);
    idle(5);
    check("glitch_next_byte", 32'(got_at(0)), 32'h5A);

    // Stop bit held low: one frameErr, byte dropped, receiver recovers.
    got_q.delete();
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 20, -1, -1);
    idle(5);
    check("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("ferr_bytes", 32'(got_q.size()), 32'd0);
    send_frame(8'h12, 1'b1, COUNT, -1, -1);
    idle(5);
    check("ferr_next_count", 32'(got_q.size()), 32'd1);
    check("ferr_next_byte", 32'(got_at(0)), 32'h12);

    // Overrun: consumer stalled, second byte is lost.
    got_q.delete();
    ov0 = ov_cnt;
    dOutReady = 1'b0;
    send_frame(8'h11, 1'b1, COUNT, -1, -1);
    send_frame(8'h22, 1'b1, COUNT, -1, -1);
    idle(5);
    check("ovr_dOut", 32'(dOut), 32'h11);
    check("ovr_valid", 32'(dOutValid), 32'h1);
    check("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
    dOutReady = 1'b1;
    idle(3);
    check("ovr_drain", 32'(got_at(0)), 32'h11);
    check("ovr_drain_valid", 32'(dOutValid), 32'h0);

    // Acceptance on the completion cycle makes room for the new byte.
    got_q.delete();
    ov0 = ov_cnt;
    dOutReady = 1'b0;
    send_frame(8'h11, 1'b1, COUNT, -1, -1);
    send_frame(8'h22, 1'b1, COUNT, LATENCY, -1);
    idle(5);
    check("swap_dOut", 32'(dOut), 32'h22);
    check("swap_valid", 32'(dOutValid), 32'h1);
    check("swap_overrun", 32'(ov_cnt - ov0), 32'd0);
    check("swap_first", 32'(got_at(0)), 32'h11);
    dOutReady = 1'b1;
    idle(3);
    check("swap_second", 32'(got_at(1)), 32'h22);

    // Reset mid-frame clears a pending byte and abandons the partial one.
    rb = 8'($urandom_range(1, 255));
    dOutReady = 1'b0;
    send_frame(rb, 1'b1, COUNT, -1, -1);
    idle(3);
    check("pend_dOut", 32'(dOut), 32'(rb));
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h99, 1'b1, COUNT, -1, 5 * COUNT + 5);
    check("midrst_dOut", 32'(dOut), 32'h00);
    check("midrst_valid", 32'(dOutValid), 32'h0);
    check("midrst_frameErr", 32'(frameErr), 32'h0);
    check("midrst_overrun", 32'(overrun), 32'h0);
    got_q.delete();
    dOutReady = 1'b1;
    idle(150);
    check("midrst_no_bytes", 32'(got_q.size()), 32'd0);
    check("midrst_no_errors", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    send_frame(8'h42, 1'b1, COUNT, -1, -1);
    idle(5);
    check("midrst_next", 32'(got_at(0)), 32'h42);

    // Random bytes with random idle gaps, compared against the sent stream.
    got_q.delete();
    exp_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    n = 12;
    for (int i = 0; i < n; i++) begin
      rb = 8'($urandom);
      exp_q.push_back(rb);
      send_frame(rb, 1'b1, COUNT, -1, -1);
      idle($urandom_range(0, 3));
    end
    idle(5);
    check("rand_count", 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n; i++) check($sformatf("rand_byte%0d", i), 32'(got_at(i)), 32'(exp_q[i]));
    check("rand_errors", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    check("never_both_pulses", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
